// File: rtl/serial_operand_buffer.sv
`default_nettype none
// ============================================================================
// Module      : serial_operand_buffer
// Description : Byte-to-serial operand buffer wrapped around a serial ALU.
//               Optional protocol error flag: SERIAL_OPERAND_BUFFER_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_operand_buffer #(
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                pair,
  input  logic                load,
  input  logic                store,
  input  logic                rx_valid,
  output logic                rx_ready,
  input  logic [REG_BITS-1:0] rx_data,
  output logic                operand_ready,
  input  logic                active,
  output logic [NSHIFT-1:0]   data_in,
  input  logic [NSHIFT-1:0]   data_out,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [REG_BITS-1:0] tx_data,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int BUF_W       = 2 * REG_BITS;
  localparam int CHUNKS_FULL = BUF_W / NSHIFT;
  localparam int CHUNKS_HALF = REG_BITS / NSHIFT;
  localparam int CNT_W       = $clog2(CHUNKS_FULL) + 1;

  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(CHUNKS_FULL - 1);
  localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(CHUNKS_HALF - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic             pair_q;
  logic             store_q;
  logic             idx;
  logic [CNT_W-1:0] cnt;
  logic [BUF_W-1:0] sbuf;
  logic             done_q;

  logic rx_fire;
  logic tx_fire;
  logic shift_en;
  logic last_byte;
  logic last_chunk;
  logic complete;

  assign rx_fire    = (state == ST_FILL) && rx_valid;
  assign tx_fire    = (state == ST_DRAIN) && tx_ready;
  assign shift_en   = (state == ST_SHIFT) && active;
  assign last_byte  = (idx == pair_q);
  assign last_chunk = shift_en && (cnt == (pair_q ? LAST_FULL : LAST_HALF));
  assign complete   = (last_chunk && !store_q) || (tx_fire && last_byte);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = load ? ST_FILL : ST_SHIFT;
      ST_FILL:  if (rx_fire && last_byte) next_state = ST_SHIFT;
      ST_SHIFT: if (last_chunk) next_state = store_q ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (tx_fire && last_byte) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pair_q  <= 1'b0;
      store_q <= 1'b0;
      idx     <= 1'b0;
      cnt     <= '0;
      sbuf    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= complete;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pair_q  <= pair;
            store_q <= store;
            idx     <= 1'b0;
            cnt     <= '0;
            if (!load) sbuf <= '0;
          end
        end
        ST_FILL: begin
          if (rx_valid) begin
            if (idx) sbuf[BUF_W-1:REG_BITS] <= rx_data;
            else     sbuf[REG_BITS-1:0]     <= rx_data;
            // Rewind so the drain phase starts from the low byte.
            idx <= last_byte ? 1'b0 : 1'b1;
          end
        end
        ST_SHIFT: begin
          if (active) begin
            if (pair_q) sbuf <= {data_out, sbuf[BUF_W-1:NSHIFT]};
            else        sbuf[REG_BITS-1:0] <= {data_out, sbuf[REG_BITS-1:NSHIFT]};
            cnt <= last_chunk ? '0 : cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (tx_ready) idx <= last_byte ? 1'b0 : 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rx_ready      = (state == ST_FILL);
    operand_ready = (state == ST_SHIFT);
    tx_valid      = (state == ST_DRAIN);
    busy          = (state != ST_IDLE);
    data_in       = (state == ST_SHIFT) ? sbuf[NSHIFT-1:0] : '0;
    tx_data       = '0;
    if (state == ST_DRAIN) tx_data = idx ? sbuf[BUF_W-1:REG_BITS] : sbuf[REG_BITS-1:0];
  end

  assign done = done_q;

`ifdef SERIAL_OPERAND_BUFFER_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else if ((active && (state != ST_SHIFT)) || (start && (state != ST_IDLE))) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_operand_buffer.sv
`default_nettype none
// Randomized scoreboard bench for serial_operand_buffer: an operand/result
// model computed from whole words feeds queues that a negedge monitor drains.
module tb_serial_operand_buffer;
  localparam int RB = 8;
  localparam int NS = 2;

  logic          clk = 1'b0;
  logic          reset, start, pair, load, store;
  logic          rx_valid, rx_ready, operand_ready, active;
  logic          tx_valid, tx_ready, busy, done, err;
  logic [RB-1:0] rx_data, tx_data;
  logic [NS-1:0] data_in, data_out;

  int checks   = 0;
  int failures = 0;
  logic [NS-1:0] exp_din_q[$];
  logic [RB-1:0] exp_tx_q[$];
  logic          done_exp = 1'b0;

  always #5 clk = ~clk;

  serial_operand_buffer #(.REG_BITS(RB), .NSHIFT(NS)) dut (
    .clk(clk), .reset(reset), .start(start), .pair(pair), .load(load), .store(store),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .operand_ready(operand_ready), .active(active), .data_in(data_in), .data_out(data_out),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every consumed chunk and every presented result byte.
  always @(negedge clk) begin
    if (!reset) begin
      if (operand_ready && active) begin
        if (exp_din_q.size() == 0) fail_now("data_in_unexpected");
        else check("data_in", data_in, exp_din_q.pop_front());
      end
      if (tx_valid) begin
        if (exp_tx_q.size() == 0) fail_now("tx_unexpected");
        else begin
          check("tx_data", tx_data, exp_tx_q[0]);
          if (tx_ready) void'(exp_tx_q.pop_front());
        end
      end
      if (done || done_exp) check("done", done, done_exp);
    end
  end

  // dmode: 0 random data_out, 1 loop back the operand, 2 constant dconst.
  // amode: 0 random active, 1 always, 2 toggling starting low.
  task automatic run_txn(input bit p, input bit ld, input bit st, input int dmode,
                         input int amode, input int stall, input bit [15:0] opnd,
                         input bit [1:0] dconst, input int abort_after);
    int        limit, k, guard, cyc, shift_cycles, b;
    bit [15:0] op, res;
    limit = p ? 2*RB/NS : RB/NS;
    op    = ld ? (p ? opnd : {8'h00, opnd[7:0]}) : 16'h0000;
    res   = 16'h0000;
    k = 0; guard = 0; cyc = 0; shift_cycles = 0;
    for (int i = 0; i < limit; i++) exp_din_q.push_back(op[NS*i +: NS]);

    start = 1'b1; pair = p; load = ld; store = st;
    tick();
    start = 1'b0;

    if (ld) begin
      for (int j = 0; j <= int'(p); j++) begin
        rx_valid = 1'b1;
        rx_data  = op[RB*j +: RB];
        guard    = 0;
        do begin
          @(negedge clk);
          guard++;
        end while (!rx_ready && guard < 50);
        if (!rx_ready) fail_now("rx_ready_timeout");
        tick();
      end
      rx_valid = 1'b0;
    end

    while (k < limit && guard < 400 && !(abort_after > 0 && k >= abort_after)) begin
      case (amode)
        0:       active = ($urandom_range(0, 3) != 0);
        1:       active = 1'b1;
        default: active = (cyc % 2 == 1);
      endcase
      case (dmode)
        0:       data_out = NS'($urandom);
        1:       data_out = op[NS*k +: NS];
        default: data_out = dconst;
      endcase
      @(negedge clk);
      if (operand_ready) shift_cycles++;
      if (active && operand_ready) begin
        res[NS*k +: NS] = data_out;
        k++;
      end
      guard++;
      cyc++;
      tick();
    end
    if (abort_after > 0 && k >= abort_after) return;
    active = 1'b0;
    if (k < limit) fail_now("shift_timeout");
    if (amode == 2) check("shift_cycles", shift_cycles, 2*limit);

    if (st) begin
      exp_tx_q.push_back(res[7:0]);
      if (p) exp_tx_q.push_back(res[15:8]);
      b = 0; guard = 0;
      while (b <= int'(p) && guard < 100) begin
        tx_ready = (guard < stall) ? 1'b0 : ($urandom_range(0, 2) != 0);
        @(negedge clk);
        if (guard < stall) check("tx_valid_held", tx_valid, 1);
        if (tx_valid && tx_ready) b++;
        guard++;
        tick();
      end
      tx_ready = 1'b0;
      if (b <= int'(p)) fail_now("drain_timeout");
    end

    done_exp = 1'b1;
    @(negedge clk);
    check("busy_after_done", busy, 0);
    tick();
    done_exp = 1'b0;
    check("din_queue_left", exp_din_q.size(), 0);
    check("tx_queue_left", exp_tx_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rx_ready"}, rx_ready, 0);
    check({tag, "_operand_ready"}, operand_ready, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_data_in"}, data_in, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; pair = 1'b0; load = 1'b0; store = 1'b0;
    rx_valid = 1'b0; rx_data = '0; active = 1'b0; data_out = '0; tx_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_idle_outputs("reset");
    tick();
    reset = 1'b0;
    tick();

    run_txn(1, 1, 1, 1, 1, 0, 16'h1234, 2'b00, 0);
    run_txn(0, 1, 1, 2, 1, 0, 16'h00A5, 2'b11, 0);
    run_txn(1, 0, 1, 2, 2, 0, 16'h0000, 2'b01, 0);
    run_txn(1, 1, 1, 1, 1, 5, 16'h1234, 2'b00, 0);

    run_txn(1, 0, 1, 0, 1, 0, 16'h0000, 2'b00, 3);
    reset  = 1'b1;
    active = 1'b0;
    tick();
    @(negedge clk);
    check_idle_outputs("abort");
    exp_din_q.delete();
    exp_tx_q.delete();
    reset = 1'b0;
    tick();
    run_txn(1, 1, 1, 1, 1, 0, 16'hBEEF, 2'b00, 0);

    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0,
              16'($urandom), 2'b00, 0);
      if ($urandom_range(0, 1) == 1) tick();
    end
    check("err_clean", err, 0);

    active = 1'b1;
    tick();
    active = 1'b0;
    @(negedge clk);
`ifdef SERIAL_OPERAND_BUFFER_ERR_EN
    check("err_set", err, 1);
    tick();
    @(negedge clk);
    check("err_sticky", err, 1);
`else
    check("err_tied", err, 0);
    tick();
    @(negedge clk);
    check("err_tied_hold", err, 0);
`endif
    check("busy_after_stray_active", busy, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("err_after_reset", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
